ps_serializer: RTL

- Parallel-to-serial stage directly downstream of the 2:1 byte multiplexer.
- Consumes the mux's 8-bit data_out/valid_out pair and emits a 1-bit stream at clk8f, one bit per clock.
- After reset it emits a run of comma (sync) characters. It then emits data bytes when the input is valid and idle characters when it is not.
- Generates its own byte framing from an internal 3-bit bit counter, so no slower clock is needed.

---
 rtl/ps_serializer_if.sv | 20 ++
 rtl/ps_serializer.sv | 102 ++++++++++
 2 files changed

// File: rtl/ps_serializer_if.sv
// Byte-in / bit-out bundle between the upstream mux and ps_serializer.
// The design plugs into the slave modport; the upstream side uses master.
interface ps_serializer_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       frame_start;
   logic       byte_ack;
   logic       active;

   modport master (
      output data_in, valid_in,
      input  data_out, frame_start, byte_ack, active
   );

   modport slave (
      input  data_in, valid_in,
      output data_out, frame_start, byte_ack, active
   );
endinterface

// File: rtl/ps_serializer.sv
// Parallel-to-serial stage: COMMA preamble after reset, then data or IDLE characters, one bit per clk8f.
// Optional build macro SER_LSB_FIRST_EN shifts characters out LSB first.
module ps_serializer #(
   parameter int         SYNC_COUNT = 4,
   parameter logic [7:0] COMMA      = 8'hBC,
   parameter logic [7:0] IDLE       = 8'h7C
) (
   input logic            clk8f,
   input logic            reset,
   ps_serializer_if.slave ser
);

   typedef enum logic {SYNC, ACTIVE} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sync_cnt_q, sync_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       dout_q, dout_d;
   logic       fs_q, fs_d;
   logic       ack_q, ack_d;
   logic       act_q, act_d;

   logic [7:0] ch;
   logic [8:0] sync_inc;

   assign sync_inc = {1'b0, sync_cnt_q} + 9'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 3'd1;
      sync_cnt_d = sync_cnt_q;
      shreg_d    = shreg_q;
      dout_d     = dout_q;
      fs_d       = 1'b0;
      ack_d      = 1'b0;
      act_d      = act_q;
      ch         = IDLE;

      if (cnt_q == 3'd7) begin
         // With no preamble the first load edge already follows ACTIVE rules.
         if (state_q == ACTIVE || SYNC_COUNT == 0) begin
            state_d = ACTIVE;
            act_d   = 1'b1;
            if (ser.valid_in) begin
               ch    = ser.data_in;
               ack_d = 1'b1;
            end
         end else begin
            ch         = COMMA;
            sync_cnt_d = sync_inc[7:0];
            if (sync_inc == 9'(SYNC_COUNT))
               state_d = ACTIVE;
         end
         fs_d = 1'b1;
`ifdef SER_LSB_FIRST_EN
         dout_d  = ch[0];
         shreg_d = {1'b0, ch[7:1]};
`else
         dout_d  = ch[7];
         shreg_d = {ch[6:0], 1'b0};
`endif
      end else begin
`ifdef SER_LSB_FIRST_EN
         dout_d  = shreg_q[0];
         shreg_d = {1'b0, shreg_q[7:1]};
`else
         dout_d  = shreg_q[7];
         shreg_d = {shreg_q[6:0], 1'b0};
`endif
      end
   end

   // cnt resets to 7 so the first edge after release is a load edge.
   always_ff @(posedge clk8f or posedge reset) begin
      if (reset) begin
         state_q    <= SYNC;
         cnt_q      <= 3'd7;
         sync_cnt_q <= 8'd0;
         shreg_q    <= 8'd0;
         dout_q     <= 1'b0;
         fs_q       <= 1'b0;
         ack_q      <= 1'b0;
         act_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sync_cnt_q <= sync_cnt_d;
         shreg_q    <= shreg_d;
         dout_q     <= dout_d;
         fs_q       <= fs_d;
         ack_q      <= ack_d;
         act_q      <= act_d;
      end
   end

   assign ser.data_out    = dout_q;
   assign ser.frame_start = fs_q;
   assign ser.byte_ack    = ack_q;
   assign ser.active      = act_q;

endmodule
